// File: rtl/sim_mem_pkg.sv
// Shared constants for the simulation memory with Apple-1 style PIA window.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sim_mem_pkg;

  // Register offsets inside the 4-register PIA window (a[1:0]).
  typedef enum logic [1:0] {
    KBD   = 2'd0,
    KBDCR = 2'd1,
    DSP   = 2'd2,
    DSPCR = 2'd3
  } pia_reg_e;

  localparam int          ASCII_W         = 7;
  localparam logic [15:0] PIA_BASE_DEF    = 16'hd010;
  localparam logic [15:0] MIRROR_MASK_DEF = 16'h00e0;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO used for the keyboard and display queues.
// Latency: a pushed word is visible at rdata the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; full is judged before this cycle's pop.
// Ports: eclk/ereset (async, active high), push/wdata in, pop in, rdata (head), full, empty.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         eclk,
  input  logic         ereset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge eclk or posedge ereset) begin
    if (ereset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; pointers define what is valid.
  always_ff @(posedge eclk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/sim_mem_pia.sv
// CPU simulation RAM with a memory-mapped keyboard/display PIA, both queued through FIFOs to the host.
// Latency: dout is registered, one eclk after the address; CPU accesses act on the clk falling-edge strobe.
// Backpressure: key_ready drops when the keyboard FIFO is full; CPU display writes into a full FIFO are counted in disp_ovf and dropped.
// Ports: eclk/ereset; CPU bus clk, a, din, dout, rw; host key_valid/key_data/key_ready; host disp_valid/disp_data/disp_ready; disp_ovf.
module sim_mem_pia
  import sim_mem_pkg::*;
#(
  parameter int          AW          = 16,
  parameter int          DW          = 8,
  parameter logic [AW-1:0] PIA_BASE    = AW'(PIA_BASE_DEF),
  parameter logic [AW-1:0] MIRROR_MASK = AW'(MIRROR_MASK_DEF),
  parameter int          KFIFO_DEPTH = 4,
  parameter int          DFIFO_DEPTH = 4,
  parameter bit          SKIP_FIRST  = 1'b1
) (
  input  logic               eclk,
  input  logic               ereset,
  input  logic               clk,
  input  logic [AW-1:0]      a,
  input  logic [DW-1:0]      din,
  output logic [DW-1:0]      dout,
  input  logic               rw,
  input  logic               key_valid,
  input  logic [ASCII_W-1:0] key_data,
  output logic               key_ready,
  output logic               disp_valid,
  output logic [ASCII_W-1:0] disp_data,
  input  logic               disp_ready,
  output logic [7:0]         disp_ovf
);

  // Window decode ignores the mirror bits and the two register-select bits.
  localparam logic [AW-1:0] DEC_MASK = ~(MIRROR_MASK | AW'(3));

  logic [DW-1:0]      ram [0:(2**AW)-1];
  logic               clk1;
  logic               strobe;
  logic               pia_hit;
  pia_reg_e           pia_reg;
  logic               kbd_rd;
  logic               dsp_wr;
  logic               drop;
  logic               first;
  logic [ASCII_W-1:0] k_head;
  logic               k_full;
  logic               k_empty;
  logic               d_full;
  logic               d_empty;
  logic [DW-1:0]      rd_val;

  assign strobe  = clk1 & ~clk;
  assign pia_hit = ((a & DEC_MASK) == (PIA_BASE & DEC_MASK));
  assign pia_reg = pia_reg_e'(a[1:0]);
  assign kbd_rd  = strobe & rw & pia_hit & (pia_reg == KBD);
  assign dsp_wr  = strobe & ~rw & pia_hit & (pia_reg == DSP);
  assign drop    = first & SKIP_FIRST;

  assign key_ready  = ~k_full;
  assign disp_valid = ~d_empty;

  sync_fifo #(.W(ASCII_W), .DEPTH(KFIFO_DEPTH)) u_kfifo (
    .eclk   (eclk),
    .ereset (ereset),
    .push   (key_valid),
    .pop    (kbd_rd),
    .wdata  (key_data),
    .rdata  (k_head),
    .full   (k_full),
    .empty  (k_empty)
  );

  sync_fifo #(.W(ASCII_W), .DEPTH(DFIFO_DEPTH)) u_dfifo (
    .eclk   (eclk),
    .ereset (ereset),
    .push   (dsp_wr & ~drop),
    .pop    (disp_ready),
    .wdata  (din[ASCII_W-1:0]),
    .rdata  (disp_data),
    .full   (d_full),
    .empty  (d_empty)
  );

  // Read mux: PIA status bits overlay the RAM shadow of the register.
  always_comb begin
    rd_val = ram[a];
    if (pia_hit) begin
      case (pia_reg)
        KBD: begin
          rd_val = '0;
          if (!k_empty) rd_val[7:0] = {1'b1, k_head};
        end
        KBDCR:   rd_val[7] = ~k_empty;
        DSP:     rd_val[7] = d_full;
        default: rd_val = ram[a];
      endcase
    end
  end

  always_ff @(posedge eclk or posedge ereset) begin
    if (ereset) begin
      dout     <= '0;
      clk1     <= 1'b0;
      first    <= 1'b1;
      disp_ovf <= '0;
    end else begin
      dout <= rd_val;
      clk1 <= clk;
      if (dsp_wr) first <= 1'b0;
      // Push to a full display FIFO is lost even if the host pops this cycle.
      if (dsp_wr && !drop && d_full && disp_ovf != 8'hff)
        disp_ovf <= disp_ovf + 8'd1;
    end
  end

  // Every CPU write lands in RAM, PIA registers included, so they read back as shadows.
  always_ff @(posedge eclk) begin
    if (strobe && !rw) ram[a] <= din;
  end

endmodule
